rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite / write_reg / write_data) between two writeback requesters: A (ALU writeback) and B (memory/load writeback).
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered, single-cycle-latency drive of the write port.
- Enforces the MIPS rule that register 0 is never written: such writes are consumed, dropped, flagged and counted.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register index width (32 registers).
- CNT_WIDTH, 8, width of the dropped-r0-write counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- hold  input  1  stall; while 1 no request is accepted.
- a_valid  input  1  requester A has a write pending.
- a_ready  output  1  A's request accepted this cycle (combinational).
- a_reg  input  ADDR_WIDTH  A's destination register.
- a_data  input  DATA_WIDTH  A's write data.
- b_valid  input  1  requester B has a write pending.
- b_ready  output  1  B's request accepted this cycle (combinational).
- b_reg  input  ADDR_WIDTH  B's destination register.
- b_data  input  DATA_WIDTH  B's write data.
- RegWrite  output  1  register-file write enable (registered).
- write_reg  output  ADDR_WIDTH  register-file write index (registered).
- write_data  output  DATA_WIDTH  register-file write data (registered).
- r0_err  output  1  one-cycle pulse: an accepted write targeted register 0.
- drop_count  output  CNT_WIDTH  saturating count of dropped r0 writes.

Behaviour:
- State: last_grant pointer (0=A, 1=B), plus output registers and counter.
- Reset (rst_n=0, asynchronous): RegWrite=0, write_reg=0, write_data=0, r0_err=0, drop_count=0, last_grant=B, so A wins the first tie.
- Grant rules (combinational, only when hold=0):
  - Only A valid -> A granted.
  - Only B valid -> B granted.
  - Both valid -> side opposite last_grant granted.
  - Neither valid -> none granted.
- x_ready = x_valid & ~hold & granted_x. The ungranted requester sees ready=0 and must hold its valid/reg/data stable.
- Transfer: occurs when x_valid & x_ready at a rising edge. At most one transfer per cycle. last_grant updates to the granted side on every transfer.
- Transfer with x_reg != 0, at the next edge:
  - RegWrite=1.
  - write_reg=x_reg, write_data=x_data.
  - Latency is exactly one cycle from acceptance to RegWrite high.
- Transfer with x_reg == 0:
  - Request is consumed (ready=1).
  - Next cycle: RegWrite=0, r0_err=1 for exactly one cycle.
  - drop_count increments, saturating at 2^CNT_WIDTH-1 (no wrap).
  - write_reg and write_data keep their previous values.
- No transfer (idle or hold=1): next cycle RegWrite=0, r0_err=0. write_reg, write_data and last_grant are unchanged.
- Fairness: with both requesters continuously valid and hold=0, grants alternate A,B,A,B… and neither waits more than one cycle.
- Same destination register from A and B in the same cycle: treated as ordinary contention; writes land in grant order, one per cycle.
- hold asserted while both are waiting: no grant; after hold falls, arbitration resumes from the unchanged pointer.
- Reset asserted mid-operation: outputs clear immediately (asynchronously); any registered-but-not-yet-written transfer is lost. Requesters re-present after reset.

Test Plan:
- After reset, a_valid=1, a_reg=2, a_data=13 for one cycle -> a_ready=1 that cycle; next cycle RegWrite=1, write_reg=2, write_data=13; following cycle RegWrite=0.
- b_valid=1, b_reg=0, b_data=13 -> b_ready=1; next cycle RegWrite=0, r0_err=1 for one cycle, drop_count 0->1.
- Both valid for 4 cycles (a_reg=3/a_data=0xA, b_reg=4/b_data=0xB) -> writes reg3, reg4, reg3, reg4 on consecutive cycles, starting with A after reset.
- Both valid with hold=1 for 3 cycles -> a_ready=b_ready=0 and RegWrite=0 throughout; on release the pending requester opposite last_grant is served first.
- Issue 300 r0 writes with CNT_WIDTH=8 -> drop_count saturates at 255; r0_err still pulses on each drop.
- Assert rst_n=0 mid-stream, between clock edges, while RegWrite=1 -> RegWrite, write_reg, write_data and drop_count read 0 immediately; after release A wins the first tie.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the two writeback request channels and the shared register-file
// write port. Requesters plus the register file sit on the master side.
interface rf_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
);
  logic                  hold;
  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  r0_err;
  logic [CNT_WIDTH-1:0]  drop_count;

  modport master (
    output hold, a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, RegWrite, write_reg, write_data, r0_err, drop_count
  );

  modport slave (
    input  hold, a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, RegWrite, write_reg, write_data, r0_err, drop_count
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU (A) and
// load (B) writeback; writes to r0 are consumed, flagged and counted.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst_n,
  rf_write_arbiter_if.slave bus
);

  localparam logic [0:0]           GRANT_A = 1'b0;
  localparam logic [0:0]           GRANT_B = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]            last_grant;
  logic                  grant_a;
  logic                  grant_b;
  logic                  xfer;
  logic                  sel_is_r0;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;

  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!bus.hold) begin
      if (bus.a_valid && bus.b_valid) begin
        // Contention: serve the side that did not win last time.
        grant_a = (last_grant == GRANT_B);
        grant_b = ~grant_a;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign xfer        = grant_a | grant_b;
  assign sel_reg     = grant_b ? bus.b_reg  : bus.a_reg;
  assign sel_data    = grant_b ? bus.b_data : bus.a_data;
  assign sel_is_r0   = (sel_reg == '0);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant     <= GRANT_B;
      bus.RegWrite   <= 1'b0;
      bus.write_reg  <= '0;
      bus.write_data <= '0;
      bus.r0_err     <= 1'b0;
      bus.drop_count <= '0;
    end else begin
      bus.RegWrite <= xfer & ~sel_is_r0;
      bus.r0_err   <= xfer & sel_is_r0;
      if (xfer) begin
        last_grant <= grant_b ? GRANT_B : GRANT_A;
        if (sel_is_r0) begin
          // Address/data keep their old values so r0 never reaches the file.
          if (bus.drop_count != CNT_MAX) bus.drop_count <= bus.drop_count + 1'b1;
        end else begin
          bus.write_reg  <= sel_reg;
          bus.write_data <= sel_data;
        end
      end
    end
  end

endmodule
